// File: rtl/picocpu_ctrl_pkg.sv
// Shared definitions for the picoComputer accumulator micro-sequencer:
// command opcodes, FSM state encoding and default widths.
package picocpu_ctrl_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int OC_W_DEF   = 3;
    localparam int CNT_W_DEF  = 4;
    localparam int OP_W       = 3;

    localparam logic [OP_W-1:0] CMD_NOP  = 3'd0;
    localparam logic [OP_W-1:0] CMD_CLR  = 3'd1;
    localparam logic [OP_W-1:0] CMD_LOAD = 3'd2;
    localparam logic [OP_W-1:0] CMD_ALU  = 3'd3;
    localparam logic [OP_W-1:0] CMD_INC  = 3'd4;
    localparam logic [OP_W-1:0] CMD_DEC  = 3'd5;
    localparam logic [OP_W-1:0] CMD_SHL  = 3'd6;
    localparam logic [OP_W-1:0] CMD_SHR  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Ops 4..7 repeat their strobe for cmd_cnt cycles.
    function automatic logic op_is_rep(input logic [OP_W-1:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/alu_reg_sequencer_rep_counter.sv
// Loadable down-counter for repeated ops; last_o flags the final EXEC cycle.
// Stops at zero rather than wrapping.
module rep_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             last_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/alu_reg_sequencer.sv
// Micro-sequencer driving the accumulator strobes and ALU operands.
// Accept -> N EXEC cycles -> one DONE cycle; cmd_ready low while busy, no buffering.
module alu_reg_sequencer
    import picocpu_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OC_W   = OC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [OC_W-1:0]   cmd_oc,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [CNT_W-1:0]  cmd_cnt,
    output logic [OC_W-1:0]   alu_oc,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_f,
    output logic              reg_cl,
    output logic              reg_ld,
    output logic              reg_inc,
    output logic              reg_dec,
    output logic              reg_sr,
    output logic              reg_sl,
    output logic              reg_ir,
    output logic              reg_il,
    output logic [DATA_W-1:0] reg_in,
    input  logic [DATA_W-1:0] reg_out,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    state_t              state_q, state_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [OC_W-1:0]     oc_q, oc_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                accept;
    logic                in_exec;
    logic                cnt_last;

    assign accept  = cmd_valid && (state_q == S_IDLE);
    assign in_exec = (state_q == S_EXEC);

    rep_counter #(
        .CNT_W (CNT_W)
    ) u_rep_counter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (accept),
        .load_val_i (cmd_cnt),
        .dec_i      (in_exec),
        .last_o     (cnt_last)
    );

    // State and latched-command registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= CMD_NOP;
            oc_q     <= '0;
            data_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            oc_q     <= oc_d;
            data_q   <= data_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = accept ? cmd_op   : op_q;
        oc_d     = accept ? cmd_oc   : oc_q;
        data_d   = accept ? cmd_data : data_q;
        result_d = (state_q == S_DONE) ? reg_out : result_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    // Nothing to strobe: go straight to the completion pulse.
                    if ((cmd_op == CMD_NOP) || (op_is_rep(cmd_op) && (cmd_cnt == '0))) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                if (!op_is_rep(op_q) || cnt_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore strobe decode from registered state and latched command
    always_comb begin
        reg_cl  = 1'b0;
        reg_ld  = 1'b0;
        reg_inc = 1'b0;
        reg_dec = 1'b0;
        reg_sl  = 1'b0;
        reg_sr  = 1'b0;
        reg_il  = 1'b0;
        reg_ir  = 1'b0;
        reg_in  = '0;
        if (in_exec) begin
            case (op_q)
                CMD_CLR:  reg_cl = 1'b1;
                CMD_LOAD: begin
                    reg_ld = 1'b1;
                    reg_in = data_q;
                end
                CMD_ALU: begin
                    reg_ld = 1'b1;
                    reg_in = alu_f;
                end
                CMD_INC:  reg_inc = 1'b1;
                CMD_DEC:  reg_dec = 1'b1;
                CMD_SHL: begin
                    reg_sl = 1'b1;
                    reg_il = data_q[0];
                end
                CMD_SHR: begin
                    reg_sr = 1'b1;
                    reg_ir = data_q[0];
                end
                default: ;
            endcase
        end
    end

    assign alu_oc    = oc_q;
    assign alu_b     = data_q;
    assign alu_a     = reg_out;
    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    // Present the final value during the done pulse, then hold it.
    assign result    = done ? reg_out : result_q;

endmodule

// File: tb/tb_alu_reg_sequencer.sv
// Directed bench: register/ALU environment model plus a done-driven scoreboard.
module tb_alu_reg_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = '0;
    logic [2:0] cmd_oc = '0;
    logic [3:0] cmd_data = '0;
    logic [3:0] cmd_cnt = '0;
    logic [2:0] alu_oc;
    logic [3:0] alu_a, alu_b, alu_f;
    logic       reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl, reg_ir, reg_il;
    logic [3:0] reg_in;
    logic [3:0] reg_out = 4'h0;
    logic       busy, done;
    logic [3:0] result;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    alu_reg_sequencer dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_oc(cmd_oc), .cmd_data(cmd_data), .cmd_cnt(cmd_cnt),
        .alu_oc(alu_oc), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
        .reg_cl(reg_cl), .reg_ld(reg_ld), .reg_inc(reg_inc), .reg_dec(reg_dec),
        .reg_sr(reg_sr), .reg_sl(reg_sl), .reg_ir(reg_ir), .reg_il(reg_il),
        .reg_in(reg_in), .reg_out(reg_out), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Environment: combinational ALU and the accumulator register
    always_comb begin
        case (alu_oc)
            3'd0: alu_f = alu_a + alu_b;
            3'd1: alu_f = alu_a - alu_b;
            3'd2: alu_f = alu_a & alu_b;
            3'd3: alu_f = alu_a | alu_b;
            3'd4: alu_f = alu_a ^ alu_b;
            3'd5: alu_f = ~alu_a;
            3'd6: alu_f = alu_a;
            default: alu_f = alu_b;
        endcase
    end

    always @(posedge clk) begin
        if (reg_cl)       reg_out <= 4'h0;
        else if (reg_ld)  reg_out <= reg_in;
        else if (reg_inc) reg_out <= reg_out + 4'h1;
        else if (reg_dec) reg_out <= reg_out - 4'h1;
        else if (reg_sl)  reg_out <= {reg_out[2:0], reg_il};
        else if (reg_sr)  reg_out <= {reg_ir, reg_out[3:1]};
    end

    typedef struct {
        string      name;
        logic [3:0] res;
        logic [29:0] cnts;
        int         lat;
        bit         chk_ld;
        logic [3:0] ld_in;
        bit         chk_alu;
        logic [2:0] oc;
        logic [3:0] a;
        logic [3:0] b;
        bit         chk_fill;
        logic       fill;
    } exp_t;

    exp_t exp_q[$];

    function automatic logic [29:0] pk(input int cl, ld, inc, dec, sl, sr);
        return {5'(cl), 5'(ld), 5'(inc), 5'(dec), 5'(sl), 5'(sr)};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
        end
    endtask

    // Monitor state
    int         m_cl, m_ld, m_inc, m_dec, m_sl, m_sr;
    int         acc_cyc = 0;
    int         acc_n = 0;
    int         done_n = 0;
    bit         multi_hot, fill0, fill1, prev_done;
    logic [3:0] cap_in, cap_a, cap_b;
    logic [2:0] cap_oc;

    always @(negedge clk) begin
        int hot;
        exp_t e;
        hot = int'(reg_cl) + int'(reg_ld) + int'(reg_inc) + int'(reg_dec) + int'(reg_sl) + int'(reg_sr);
        if (hot > 1) multi_hot = 1'b1;
        m_cl  += int'(reg_cl);  m_ld  += int'(reg_ld);  m_inc += int'(reg_inc);
        m_dec += int'(reg_dec); m_sl  += int'(reg_sl);  m_sr  += int'(reg_sr);
        if ((reg_sl && reg_il) || (reg_sr && reg_ir))   fill1 = 1'b1;
        if ((reg_sl && !reg_il) || (reg_sr && !reg_ir)) fill0 = 1'b1;
        if (reg_ld) begin
            cap_in = reg_in; cap_oc = alu_oc; cap_a = alu_a; cap_b = alu_b;
        end
        if (prev_done) check("ready_after_done", {31'd0, cmd_ready && !busy}, 32'd1);
        prev_done = done;
        if (done) begin
            done_n++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check({e.name, "_result"}, {28'd0, result}, {28'd0, e.res});
                check({e.name, "_strobes"}, {2'd0, pk(m_cl, m_ld, m_inc, m_dec, m_sl, m_sr)}, {2'd0, e.cnts});
                check({e.name, "_latency"}, cyc - acc_cyc, e.lat);
                check({e.name, "_onehot"}, {31'd0, multi_hot}, 32'd0);
                if (e.chk_ld) check({e.name, "_reg_in"}, {28'd0, cap_in}, {28'd0, e.ld_in});
                if (e.chk_alu) check({e.name, "_alu_ops"}, {21'd0, cap_oc, cap_a, cap_b}, {21'd0, e.oc, e.a, e.b});
                if (e.chk_fill) check({e.name, "_fill"}, {30'd0, fill1, fill0}, e.fill ? 32'd2 : 32'd1);
            end
        end
        if (cmd_valid && cmd_ready && !rst) begin
            acc_cyc = cyc + 1;
            acc_n++;
            m_cl = 0; m_ld = 0; m_inc = 0; m_dec = 0; m_sl = 0; m_sr = 0;
            multi_hot = 1'b0; fill0 = 1'b0; fill1 = 1'b0;
        end
    end

    task automatic push(input string nm, input logic [3:0] res, input logic [29:0] cnts,
                        input int lat, input logic [3:0] ld_in, input bit chk_ld,
                        input bit chk_fill, input logic fill);
        exp_t e;
        e.name = nm; e.res = res; e.cnts = cnts; e.lat = lat;
        e.chk_ld = chk_ld; e.ld_in = ld_in; e.chk_alu = 1'b0;
        e.oc = '0; e.a = '0; e.b = '0;
        e.chk_fill = chk_fill; e.fill = fill;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] oc, input logic [3:0] d,
                         input logic [3:0] c, input int hold);
        int guard = 0;
        while (!cmd_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!cmd_ready) check("ready_timeout", 32'd0, 32'd1);
        cmd_op = op; cmd_oc = oc; cmd_data = d; cmd_cnt = c;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        exp_t e;
        int   a0, d0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_busy_done", {30'd0, busy, done}, 32'd0);
        check("rst_result", {28'd0, result}, 32'd0);
        check("rst_strobes", {24'd0, reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl, reg_ir, reg_il}, 32'd0);
        check("rst_regin_aluoc_alub", {21'd0, reg_in, alu_oc, alu_b}, 32'd0);

        push("load_a", 4'hA, pk(0,1,0,0,0,0), 1, 4'hA, 1'b1, 1'b0, 1'b0);
        issue(3'd2, 3'd0, 4'hA, 4'd0, 0);
        push("load_e", 4'hE, pk(0,1,0,0,0,0), 1, 4'hE, 1'b1, 1'b0, 1'b0);
        issue(3'd2, 3'd0, 4'hE, 4'd0, 0);
        push("inc3", 4'h1, pk(0,0,3,0,0,0), 3, 4'h0, 1'b0, 1'b0, 1'b0);
        issue(3'd4, 3'd0, 4'h0, 4'd3, 0);
        push("load_3", 4'h3, pk(0,1,0,0,0,0), 1, 4'h3, 1'b1, 1'b0, 1'b0);
        issue(3'd2, 3'd0, 4'h3, 4'd0, 0);
        push("shl2", 4'hF, pk(0,0,0,0,2,0), 2, 4'h0, 1'b0, 1'b1, 1'b1);
        issue(3'd6, 3'd0, 4'h1, 4'd2, 0);
        push("shr1", 4'h7, pk(0,0,0,0,0,1), 1, 4'h0, 1'b0, 1'b1, 1'b0);
        issue(3'd7, 3'd0, 4'h0, 4'd1, 0);
        push("load_6", 4'h6, pk(0,1,0,0,0,0), 1, 4'h6, 1'b1, 1'b0, 1'b0);
        issue(3'd2, 3'd0, 4'h6, 4'd0, 0);
        e.name = "alu_and"; e.res = 4'h4; e.cnts = pk(0,1,0,0,0,0); e.lat = 1;
        e.chk_ld = 1'b1; e.ld_in = 4'h4; e.chk_alu = 1'b1; e.oc = 3'd2; e.a = 4'h6; e.b = 4'h5;
        e.chk_fill = 1'b0; e.fill = 1'b0;
        exp_q.push_back(e);
        issue(3'd3, 3'd2, 4'h5, 4'd0, 0);
        push("inc0", 4'h4, pk(0,0,0,0,0,0), 0, 4'h0, 1'b0, 1'b0, 1'b0);
        issue(3'd4, 3'd0, 4'h0, 4'd0, 0);
        drain();
        a0 = acc_n;
        push("nop_held", 4'h4, pk(0,0,0,0,0,0), 0, 4'h0, 1'b0, 1'b0, 1'b0);
        issue(3'd0, 3'd0, 4'h0, 4'd0, 1);
        drain();
        check("nop_single_accept", acc_n - a0, 1);
        push("clr", 4'h0, pk(1,0,0,0,0,0), 1, 4'h0, 1'b0, 1'b0, 1'b0);
        issue(3'd1, 3'd0, 4'h0, 4'd0, 0);
        push("load_5", 4'h5, pk(0,1,0,0,0,0), 1, 4'h5, 1'b1, 1'b0, 1'b0);
        issue(3'd2, 3'd0, 4'h5, 4'd0, 0);
        push("dec15", 4'h6, pk(0,0,0,15,0,0), 15, 4'h0, 1'b0, 1'b0, 1'b0);
        issue(3'd5, 3'd0, 4'h0, 4'd15, 0);
        push("load_9", 4'h9, pk(0,1,0,0,0,0), 1, 4'h9, 1'b1, 1'b0, 1'b0);
        issue(3'd2, 3'd0, 4'h9, 4'd0, 0);
        drain();

        // DEC 10 aborted by reset after three EXEC cycles
        d0 = done_n;
        issue(3'd5, 3'd0, 4'h0, 4'd10, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort_dec_pulses", m_dec, 3);
        check("abort_no_done", done_n - d0, 0);
        check("abort_ready_idle", {30'd0, cmd_ready, busy}, 32'd2);
        check("abort_result_cleared", {28'd0, result}, 32'd0);
        check("abort_reg_kept", {28'd0, reg_out}, 32'd6);

        push("dec1_after_abort", 4'h5, pk(0,0,0,1,0,0), 1, 4'h0, 1'b0, 1'b0, 1'b0);
        issue(3'd5, 3'd0, 4'h0, 4'd1, 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
